// File: rtl/bcd_counter_ndigit_if.sv
// Control/data bundle for bcd_counter_ndigit: the master drives the controls, the slave returns the count and status.
// When BCD_LOAD_CHECK_EN is defined, the bundle also carries the err flag for clamped loads.
interface bcd_counter_ndigit_if #(
  parameter int DIGITS = 4
);
  logic                  enable;
  logic                  load;
  logic                  up;
  logic [4*DIGITS-1:0]   d;
  logic [4*DIGITS-1:0]   q;
  logic                  tc;
  logic                  ovf;
`ifdef BCD_LOAD_CHECK_EN
  logic                  err;
`endif

  modport master (
    output enable, load, up, d,
`ifdef BCD_LOAD_CHECK_EN
    input  err,
`endif
    input  q, tc, ovf
  );

  modport slave (
    input  enable, load, up, d,
`ifdef BCD_LOAD_CHECK_EN
    output err,
`endif
    output q, tc, ovf
  );
endinterface

// File: rtl/bcd_counter_ndigit.sv
// Multi-digit packed-BCD up/down counter with load, enable, wrap/saturate ends, terminal count and overflow pulse.
// Optional macro BCD_LOAD_CHECK_EN: clamps loaded digits above 9 to 9 and flags the clamp on err.
module bcd_counter_ndigit #(
  parameter int DIGITS   = 4,
  parameter bit SATURATE = 1'b0
) (
  input logic                 clk,
  input logic                 clr,
  bcd_counter_ndigit_if.slave bus
);
  localparam int W = 4 * DIGITS;

  logic [W-1:0]    q_r;
  logic [W-1:0]    step_val;
  logic [W-1:0]    load_val;
  logic [DIGITS:0] chain;
  logic [3:0]      dig;
  logic            at_end;
  logic            ovf_r;

  // chain[i] is the carry (up) or borrow (down) into digit i; chain[DIGITS] marks the range end.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves one unassigned (no latches).
    step_val = q_r;
    chain    = '0;
    chain[0] = 1'b1;
    dig      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = q_r[4*i +: 4];
      if (chain[i]) begin
        if (bus.up) begin
          // Digits A-F act as 9: roll to 0 and pass the carry on.
          if (dig >= 4'd9) begin
            step_val[4*i +: 4] = 4'd0;
            chain[i+1]         = 1'b1;
          end else begin
            step_val[4*i +: 4] = dig + 4'd1;
          end
        end else begin
          if (dig == 4'd0) begin
            step_val[4*i +: 4] = 4'd9;
            chain[i+1]         = 1'b1;
          end else if (dig > 4'd9) begin
            step_val[4*i +: 4] = 4'd8;
          end else begin
            step_val[4*i +: 4] = dig - 4'd1;
          end
        end
      end
    end
    at_end = chain[DIGITS];
  end

`ifdef BCD_LOAD_CHECK_EN
  logic clamped;
  logic err_r;

  always_comb begin
    load_val = bus.d;
    clamped  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.d[4*i +: 4] > 4'd9) begin
        load_val[4*i +: 4] = 4'd9;
        clamped            = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr)           err_r <= 1'b0;
    else if (bus.load) err_r <= clamped;
    else               err_r <= 1'b0;
  end

  assign bus.err = err_r;
`else
  assign load_val = bus.d;
`endif

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (clr) begin
      q_r   <= '0;
      ovf_r <= 1'b0;
    end else if (bus.load) begin
      q_r   <= load_val;
      ovf_r <= 1'b0;
    end else if (bus.enable) begin
      ovf_r <= at_end;
      if (!(SATURATE && at_end)) q_r <= step_val;
    end else begin
      ovf_r <= 1'b0;
    end
  end

  assign bus.q   = q_r;
  assign bus.ovf = ovf_r;
  assign bus.tc  = bus.enable & (bus.up ? (q_r == {DIGITS{4'd9}}) : (q_r == '0));
endmodule
